// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit port: register map, STATUS bit
// positions, transmitter FSM states and the bit-period helper.
package uart_tx_pkg;

  // Register offsets, selected by mem_addr[3:2]
  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  // STATUS register bit positions
  localparam int unsigned STAT_FULL  = 0;
  localparam int unsigned STAT_EMPTY = 1;
  localparam int unsigned STAT_IDLE  = 2;
  localparam int unsigned STAT_OVR   = 3;

  // Transmitter frame states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // A divisor of zero behaves like one so the line never stalls
  function automatic logic [15:0] bit_period(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra pointer bit to tell full from empty.
// A push while full is accepted only when a pop happens in the same cycle.
// DEPTH must be a power of two, at least 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en_s, rd_en_s;

  // Flag, handshake and pointer next-state logic
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rd_en_s  = pop_i & ~empty_o;
    wr_en_s  = push_i & (~full_o | rd_en_s);
    wr_ptr_d = wr_en_s ? (wr_ptr_q + PTR_INC) : wr_ptr_q;
    rd_ptr_d = rd_en_s ? (rd_ptr_q + PTR_INC) : rd_ptr_q;
    data_o   = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers; reset empties the FIFO
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/DIV registers in a 16-byte
// window, a transmit FIFO, and a bit-serial frame FSM with registered tx.
module uart_tx_port
  import uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter logic [15:0] CLK_DIV    = 16'd434,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_wren,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        tx
);

  logic        sel_s;
  logic [1:0]  off_s;
  logic        wr_data_s, wr_stat_s, wr_div_s;
  logic        fifo_full_s, fifo_empty_s, fifo_pop_s;
  logic [7:0]  fifo_rdata_s;
  logic        idle_s;
  logic [31:0] status_s;
  logic [15:0] period_s;

  tx_state_e   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic        tx_q, tx_d;

  logic [15:0] div_q, div_d;
  logic        ovr_q, ovr_d;
  logic [31:0] rdata_q, rdata_d;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .push_i (wr_data_s),
    .data_i (mem_wdata[7:0]),
    .pop_i  (fifo_pop_s),
    .data_o (fifo_rdata_s),
    .full_o (fifo_full_s),
    .empty_o(fifo_empty_s)
  );

  // Address decode and write strobes for each register
  always_comb begin
    sel_s     = (mem_addr[31:4] == BASE_ADDR[31:4]);
    off_s     = mem_addr[3:2];
    wr_data_s = mem_wren & sel_s & (off_s == OFF_DATA)   & mem_wmask[0];
    wr_stat_s = mem_wren & sel_s & (off_s == OFF_STATUS) & mem_wmask[0];
    wr_div_s  = mem_wren & sel_s & (off_s == OFF_DIV);
  end

  // DIV byte-lane update and sticky overrun (set wins over clear)
  always_comb begin
    div_d = div_q;
    if (wr_div_s && mem_wmask[0]) begin
      div_d[7:0] = mem_wdata[7:0];
    end else begin
      div_d[7:0] = div_q[7:0];
    end
    if (wr_div_s && mem_wmask[1]) begin
      div_d[15:8] = mem_wdata[15:8];
    end else begin
      div_d[15:8] = div_q[15:8];
    end
    if (wr_data_s && fifo_full_s && !fifo_pop_s) begin
      ovr_d = 1'b1;
    end else if (wr_stat_s && mem_wdata[3]) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Register file state and registered load data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q   <= CLK_DIV;
      ovr_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      div_q   <= div_d;
      ovr_q   <= ovr_d;
      rdata_q <= rdata_d;
    end
  end

  // FSM state register plus frame datapath and registered serial output
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'd0;
      bit_cnt_q  <= 3'd0;
      baud_cnt_q <= 16'd0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      tx_q       <= tx_d;
    end
  end

  // Next-state logic; the bit period is sampled only at bit boundaries
  always_comb begin
    period_s   = bit_period(div_q);
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    fifo_pop_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          shift_d    = fifo_rdata_s;
          bit_cnt_d  = 3'd7;
          baud_cnt_d = period_s - 16'd1;
          state_d    = ST_START;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_cnt_q == 16'd0) begin
          baud_cnt_d = period_s - 16'd1;
          state_d    = ST_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_cnt_q == 16'd0) begin
          baud_cnt_d = period_s - 16'd1;
          if (bit_cnt_q == 3'd0) begin
            state_d = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_cnt_q == 16'd0) begin
          state_d = ST_IDLE;
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: line level for the upcoming state, STATUS word, read mux
  always_comb begin
    case (state_d)
      ST_IDLE:  tx_d = 1'b1;
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      ST_STOP:  tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    idle_s               = fifo_empty_s & (state_q == ST_IDLE);
    status_s             = 32'd0;
    status_s[STAT_FULL]  = fifo_full_s;
    status_s[STAT_EMPTY] = fifo_empty_s;
    status_s[STAT_IDLE]  = idle_s;
    status_s[STAT_OVR]   = ovr_q;
    if (sel_s) begin
      case (off_s)
        OFF_DATA:   rdata_d = 32'd0;
        OFF_STATUS: rdata_d = status_s;
        OFF_DIV:    rdata_d = {16'd0, div_q};
        OFF_RSVD:   rdata_d = 32'd0;
        default:    rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = 32'd0;
    end
  end

  assign mem_rdata = rdata_q;
  assign tx        = tx_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port: a register-access vector table followed by
// hand-built frame, overrun, full-with-pop and reset-mid-frame sequences.
module tb_uart_tx_port;

  localparam logic [31:0] B = 32'h1000_0000;

  logic        clk;
  logic        rstn;
  logic        mem_wren;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        tx;

  int n_checks;
  int n_fail;
  logic exp_q[$];

  typedef struct {
    logic        wren;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[19];

  uart_tx_port dut (
    .clk      (clk),
    .rstn     (rstn),
    .mem_wren (mem_wren),
    .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .tx       (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive, take the rising edge, settle 1 time unit after it
  task automatic bus(input logic wren, input logic [3:0] mask, input logic [31:0] addr,
                     input logic [31:0] wdata);
    mem_wren  = wren;
    mem_wmask = mask;
    mem_addr  = addr;
    mem_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) bus(1'b0, 4'h0, B + 32'h4, 32'h0);
  endtask

  task automatic do_reset();
    mem_wren = 1'b0;
    rstn     = 1'b0;
    repeat (3) @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic add_bits(input logic v, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(v);
  endtask

  // Step once per cycle, optionally rewriting DIV at cycle chg_at, and compare tx
  task automatic run_exp(input string tag, input int chg_at, input logic [15:0] new_div);
    for (int c = 0; c < exp_q.size(); c++) begin
      if (c == chg_at) bus(1'b1, 4'b0011, B + 32'h8, {16'd0, new_div});
      else             bus(1'b0, 4'h0, B + 32'h4, 32'h0);
      check($sformatf("%s_c%0d", tag, c), {31'd0, tx}, {31'd0, exp_q[c]});
    end
  endtask

  initial begin
    logic [7:0] b;
    int bad;
    n_checks  = 0;
    n_fail    = 0;
    rstn      = 1'b0;
    mem_wren  = 1'b0;
    mem_wmask = 4'h0;
    mem_wdata = 32'h0;
    mem_addr  = 32'h0;

    // Register-access table, starting from reset state (DIV = 434)
    vecs[0]  = '{1'b0, 4'h0, B + 32'h4, 32'h0,         32'h6};
    vecs[1]  = '{1'b0, 4'h0, B + 32'h8, 32'h0,         32'h1B2};
    vecs[2]  = '{1'b1, 4'h3, B + 32'h8, 32'hABCD_1234, 32'h1B2};
    vecs[3]  = '{1'b0, 4'h0, B + 32'h8, 32'h0,         32'h1234};
    vecs[4]  = '{1'b1, 4'h2, B + 32'h8, 32'h0000_5600, 32'h1234};
    vecs[5]  = '{1'b0, 4'h0, B + 32'h8, 32'h0,         32'h5634};
    vecs[6]  = '{1'b1, 4'h1, B + 32'h8, 32'h0000_0078, 32'h5634};
    vecs[7]  = '{1'b0, 4'h0, B + 32'h8, 32'h0,         32'h5678};
    vecs[8]  = '{1'b1, 4'hC, B + 32'h8, 32'hFFFF_FFFF, 32'h5678};
    vecs[9]  = '{1'b0, 4'h0, B + 32'h8, 32'h0,         32'h5678};
    vecs[10] = '{1'b0, 4'h0, B + 32'hC, 32'h0,         32'h0};
    vecs[11] = '{1'b1, 4'hF, B + 32'hC, 32'hFFFF_FFFF, 32'h0};
    vecs[12] = '{1'b0, 4'h0, B + 32'h0, 32'h0,         32'h0};
    vecs[13] = '{1'b1, 4'hE, B + 32'h0, 32'h0000_00AA, 32'h0};
    vecs[14] = '{1'b0, 4'h0, B + 32'h6, 32'h0,         32'h6};
    vecs[15] = '{1'b0, 4'h0, B + 32'h14, 32'h0,        32'h0};
    vecs[16] = '{1'b0, 4'h0, 32'h2000_0004, 32'h0,     32'h0};
    vecs[17] = '{1'b1, 4'h1, B + 32'h4, 32'h8,         32'h6};
    vecs[18] = '{1'b0, 4'h0, B + 32'h4, 32'h0,         32'h6};

    // Reset state
    #12;
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_tx", {31'd0, tx}, 32'h1);
    do_reset();
    bus(1'b0, 4'h0, B + 32'h4, 32'h0);
    check("status_after_reset", mem_rdata, 32'h6);
    check("tx_after_reset", {31'd0, tx}, 32'h1);

    // Table-driven register accesses
    for (int i = 0; i < 19; i++) begin
      bus(vecs[i].wren, vecs[i].mask, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_rdata", i), mem_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_tx", i), {31'd0, tx}, 32'h1);
    end

    // Frame of 8'h55 at DIV=4
    do_reset();
    bus(1'b1, 4'h3, B + 32'h8, 32'h4);
    bus(1'b1, 4'h1, B + 32'h0, 32'h55);
    check("f55_pre", {31'd0, tx}, 32'h1);
    exp_q.delete();
    b = 8'h55;
    add_bits(1'b0, 4);
    for (int k = 0; k < 8; k++) add_bits(b[k], 4);
    add_bits(1'b1, 5);
    run_exp("f55", -1, 16'd0);
    bus(1'b0, 4'h0, B + 32'h4, 32'h0);
    check("f55_status", mem_rdata, 32'h6);

    // DIV 4 -> 8 in the middle of data bit 1 of 8'h4B
    do_reset();
    bus(1'b1, 4'h3, B + 32'h8, 32'h4);
    bus(1'b1, 4'h1, B + 32'h0, 32'h4B);
    exp_q.delete();
    b = 8'h4B;
    add_bits(1'b0, 4);
    add_bits(b[0], 4);
    add_bits(b[1], 4);
    for (int k = 2; k < 8; k++) add_bits(b[k], 8);
    add_bits(1'b1, 8);
    run_exp("fdiv", 10, 16'd8);

    // Overrun: transmitter busy with a prime byte, then 9 back-to-back writes
    do_reset();
    bus(1'b1, 4'h3, B + 32'h8, 32'h2);
    bus(1'b1, 4'h1, B + 32'h0, 32'hFF);
    for (int k = 0; k < 9; k++) bus(1'b1, 4'h1, B + 32'h0, k);
    bus(1'b0, 4'h0, B + 32'h4, 32'h0);
    check("ovr_status_full", mem_rdata, 32'h9);
    bus(1'b1, 4'h1, B + 32'h4, 32'h8);
    check("ovr_clear_wr_rdata", mem_rdata, 32'h9);
    bus(1'b0, 4'h0, B + 32'h4, 32'h0);
    check("ovr_cleared", mem_rdata, 32'h1);

    // Full FIFO written in the same cycle the FSM pops (DIV=1, 11-cycle frames)
    do_reset();
    bus(1'b1, 4'h3, B + 32'h8, 32'h1);
    for (int k = 0; k < 9; k++) bus(1'b1, 4'h1, B + 32'h0, 32'h10 + k);
    bus(1'b0, 4'h0, B + 32'h4, 32'h0);
    check("fullpop_before", mem_rdata, 32'h1);
    idle(2);
    bus(1'b1, 4'h1, B + 32'h0, 32'h19);
    bus(1'b0, 4'h0, B + 32'h4, 32'h0);
    check("fullpop_after", mem_rdata, 32'h1);

    // Reset asserted during a data bit with 3 bytes still queued
    do_reset();
    bus(1'b1, 4'h3, B + 32'h8, 32'h4);
    for (int k = 0; k < 4; k++) bus(1'b1, 4'h1, B + 32'h0, k);
    for (int k = 0; k < 3; k++) bus(1'b0, 4'h0, B + 32'h8, 32'h0);
    check("midrst_tx_before", {31'd0, tx}, 32'h0);
    check("midrst_rdata_before", mem_rdata, 32'h4);
    #2 rstn = 1'b0;
    #1;
    check("midrst_tx_forced", {31'd0, tx}, 32'h1);
    check("midrst_rdata_forced", mem_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    bus(1'b0, 4'h0, B + 32'h4, 32'h0);
    check("midrst_status", mem_rdata, 32'h6);
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      bus(1'b0, 4'h0, B + 32'h4, 32'h0);
      if (tx !== 1'b1) bad++;
    end
    check("midrst_no_frame", bad, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
